// File: rtl/avalon_pkg.sv
// avalon_pkg
//   Shared types and constants for the Avalon-MM RAM responder.
//   av_slv_state_t : responder FSM states (IDLE, WAIT, ACK)
//   AV_WS_MAX      : largest supported wait-state count (4-bit counter)
package avalon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } av_slv_state_t;

   localparam int AV_WS_MAX = 15;

endpackage

// File: rtl/sp_ram.sv
// sp_ram
//   Single-port word RAM with one synchronous read/write port.
//   The read-data register is also the responder's READDATA register: it
//   only loads on a read enable, so it holds the last read value and is
//   cleared by reset. The array itself is never reset.
// Ports
//   clk   in   clock, rising edge
//   rst   in   asynchronous reset, active high (read-data register only)
//   en    in   port enable
//   we    in   write enable (qualified by en)
//   addr  in   word index
//   wdata in   write data
//   rdata out  registered read data
module sp_ram #(
   parameter int    WIDTH      = 32,
   parameter int    DEPTH_LOG2 = 10,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (en && we)
         mem[addr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rdata <= '0;
      else if (en && !we)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/avalon_mm_slave_ram.sv
// avalon_mm_slave_ram
//   Avalon-MM responder in front of a single-port word RAM, with a fixed
//   number of WAITREQUEST-high wait states before each one-cycle ack.
// Ports
//   CLK, RST        clock (rising) / asynchronous reset (active high)
//   ADDRESS         byte address; word index = ADDRESS[DEPTH_LOG2+1:2]
//   BEGINTRANSFER   informational, unused
//   READ, WRITE     request strobes (write wins when both are high)
//   WRITEDATA       write data, latched at acceptance
//   LOCK            ignored
//   READDATA        read data, valid in the ack cycle, held afterwards
//   WAITREQUEST     registered stall; low only in the ack cycle
//   protocol_err    sticky flag: READ and WRITE accepted together
module avalon_mm_slave_ram
   import avalon_pkg::*;
#(
   parameter int    WIDTH       = 32,
   parameter int    DEPTH_LOG2  = 10,
   parameter int    WAIT_STATES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [31:0]      ADDRESS,
   input  logic             BEGINTRANSFER,
   input  logic             READ,
   input  logic             WRITE,
   input  logic [WIDTH-1:0] WRITEDATA,
   input  logic             LOCK,
   output logic [WIDTH-1:0] READDATA,
   output logic             WAITREQUEST,
   output logic             protocol_err
);

   localparam int WS_EFF = (WAIT_STATES > AV_WS_MAX) ? AV_WS_MAX : WAIT_STATES;
   localparam logic [3:0] WS_INIT = (WS_EFF == 0) ? 4'd0 : 4'(WS_EFF - 1);

   av_slv_state_t         state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [WIDTH-1:0]      wdata_q;
   logic                  op_wr_q;

   logic                  req;
   logic [DEPTH_LOG2-1:0] idx_in;
   logic                  rd_op;
   logic                  ram_en, ram_we;
   logic [DEPTH_LOG2-1:0] ram_addr;

   logic unused_ok;
   assign unused_ok = &{1'b0, BEGINTRANSFER, LOCK, ADDRESS[31:DEPTH_LOG2+2], ADDRESS[1:0]};

   assign req    = READ | WRITE;
   assign idx_in = ADDRESS[DEPTH_LOG2+1:2];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               if (WS_EFF == 0) begin
                  state_nxt = ACK;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = WS_INIT;
               end
            end
         end
         WAIT: begin
            // Master withdrew the request: abort without touching the RAM.
            if (!req)
               state_nxt = IDLE;
            else if (cnt == 4'd0)
               state_nxt = ACK;
            else
               cnt_nxt = cnt - 4'd1;
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With zero wait states the RAM is read straight from the bus in IDLE;
   // otherwise the latched index and op are used.
   assign rd_op    = (state == IDLE) ? !WRITE : !op_wr_q;
   assign ram_addr = (state == IDLE) ? idx_in : idx_q;
   assign ram_we   = (state == ACK) && op_wr_q;
   // Read at the edge that enters ACK so READDATA is valid during the ack.
   assign ram_en   = ram_we || ((state != ACK) && (state_nxt == ACK) && rd_op);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         idx_q        <= '0;
         wdata_q      <= '0;
         op_wr_q      <= 1'b0;
         WAITREQUEST  <= 1'b1;
         protocol_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         WAITREQUEST <= (state_nxt != ACK);
         if (state == IDLE && req) begin
            idx_q   <= idx_in;
            wdata_q <= WRITEDATA;
            op_wr_q <= WRITE;
            if (READ && WRITE)
               protocol_err <= 1'b1;
         end
      end
   end

   sp_ram #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .clk   (CLK),
      .rst   (RST),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (READDATA)
   );

   // The master must hold address and op stable while stalled.
   a_stable_in_wait : assert property (@(posedge CLK) disable iff (RST)
      (state == WAIT && req) |-> (idx_in == idx_q && WRITE == op_wr_q));

endmodule

// File: tb/tb_avalon_mm_slave_ram.sv
// tb_avalon_mm_slave_ram
//   Three responders with different geometry: u0 (WS=2, 16 words),
//   u1 (WS=0, 1024 words), u2 (WS=3, 16 words). A word-array model
//   predicts RAM contents, READDATA, latency and protocol_err.
module tb_avalon_mm_slave_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        begintransfer, lock;
   logic [31:0] address   [3];
   logic [31:0] writedata [3];
   logic [31:0] readdata  [3];
   logic        req_rd    [3];
   logic        req_wr    [3];
   logic        waitreq   [3];
   logic        perr      [3];

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_m  [3][1024];
   logic [31:0] rd_m   [3];
   logic        perr_m [3];

   avalon_mm_slave_ram #(.WIDTH(32), .DEPTH_LOG2(4), .WAIT_STATES(2)) u0 (
      .CLK(clk), .RST(rst), .ADDRESS(address[0]), .BEGINTRANSFER(begintransfer),
      .READ(req_rd[0]), .WRITE(req_wr[0]), .WRITEDATA(writedata[0]), .LOCK(lock),
      .READDATA(readdata[0]), .WAITREQUEST(waitreq[0]), .protocol_err(perr[0]));

   avalon_mm_slave_ram #(.WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) u1 (
      .CLK(clk), .RST(rst), .ADDRESS(address[1]), .BEGINTRANSFER(begintransfer),
      .READ(req_rd[1]), .WRITE(req_wr[1]), .WRITEDATA(writedata[1]), .LOCK(lock),
      .READDATA(readdata[1]), .WAITREQUEST(waitreq[1]), .protocol_err(perr[1]));

   avalon_mm_slave_ram #(.WIDTH(32), .DEPTH_LOG2(4), .WAIT_STATES(3)) u2 (
      .CLK(clk), .RST(rst), .ADDRESS(address[2]), .BEGINTRANSFER(begintransfer),
      .READ(req_rd[2]), .WRITE(req_wr[2]), .WRITEDATA(writedata[2]), .LOCK(lock),
      .READDATA(readdata[2]), .WAITREQUEST(waitreq[2]), .protocol_err(perr[2]));

   function automatic int ws_of(int d);
      return (d == 0) ? 2 : (d == 1) ? 0 : 3;
   endfunction

   function automatic int dl_of(int d);
      return (d == 1) ? 10 : 4;
   endfunction

   function automatic int widx(int d, logic [31:0] a);
      return int'((a >> 2) & ((32'd1 << dl_of(d)) - 32'd1));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the responder idle; returns at the negedge
   // of the IDLE cycle that follows the ack.
   task automatic xfer(int d, bit wr, bit rd, logic [31:0] a, logic [31:0] wd);
      int cyc = 0;
      int i;
      chk("idle_waitreq", 32'(waitreq[d]), 32'd1);
      address[d] = a; writedata[d] = wd; req_wr[d] = wr; req_rd[d] = rd;
      do begin
         @(negedge clk);
         cyc++;
      end while (waitreq[d] !== 1'b0 && cyc < 40);
      chk("ack_latency", 32'(cyc), 32'(ws_of(d) + 1));
      i = widx(d, a);
      if (rd && wr) perr_m[d] = 1'b1;
      if (wr) mem_m[d][i] = wd;
      else    rd_m[d] = mem_m[d][i];
      if (!wr) chk("ack_readdata", readdata[d], rd_m[d]);
      req_wr[d] = 1'b0; req_rd[d] = 1'b0;
      address[d] = $urandom(); writedata[d] = $urandom();
      @(negedge clk);
      chk("post_waitreq", 32'(waitreq[d]), 32'd1);
      chk("readdata_hold", readdata[d], rd_m[d]);
      chk("protocol_err", 32'(perr[d]), 32'(perr_m[d]));
   endtask

   // Write that is withdrawn after one wait cycle.
   task automatic abort_wr(int d, logic [31:0] a, logic [31:0] wd);
      address[d] = a; writedata[d] = wd; req_wr[d] = 1'b1;
      @(negedge clk);
      chk("abort_wait", 32'(waitreq[d]), 32'd1);
      req_wr[d] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(waitreq[d]), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1; begintransfer = 1'b0; lock = 1'b0;
      for (int d = 0; d < 3; d++) begin
         address[d] = '0; writedata[d] = '0; req_rd[d] = 1'b0; req_wr[d] = 1'b0;
         rd_m[d] = '0; perr_m[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("reset_waitreq", 32'(waitreq[d]), 32'd1);
         chk("reset_readdata", readdata[d], 32'd0);
         chk("reset_perr", 32'(perr[d]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Fill the low 16 words of every RAM so all later reads are defined.
      for (int d = 0; d < 3; d++)
         for (int w = 0; w < 16; w++)
            xfer(d, 1'b1, 1'b0, 32'(w * 4), $urandom());

      // WS=2 write/read at 0x10
      xfer(0, 1'b1, 1'b0, 32'h10, 32'h12345678);
      xfer(0, 1'b0, 1'b1, 32'h10, 32'h0);
      chk("t1_read", readdata[0], 32'h12345678);

      // WS=0 back-to-back reads
      xfer(1, 1'b0, 1'b1, 32'h0, 32'h0);
      xfer(1, 1'b0, 1'b1, 32'h4, 32'h0);

      // 16-word RAM wraps: 0x40 aliases 0x00
      xfer(0, 1'b1, 1'b0, 32'h40, 32'hA5A5A5A5);
      xfer(0, 1'b0, 1'b1, 32'h00, 32'h0);
      chk("t3_wrap", readdata[0], 32'hA5A5A5A5);

      // WS=3 aborted write leaves RAM untouched
      abort_wr(2, 32'h18, 32'h0BADF00D);
      xfer(2, 1'b0, 1'b1, 32'h18, 32'h0);

      // READ and WRITE together: write wins, sticky error
      xfer(1, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
      xfer(1, 1'b0, 1'b1, 32'h8, 32'h0);
      chk("t5_rd", readdata[1], 32'hCAFEF00D);
      chk("t5_sticky", 32'(perr[1]), 32'd1);

      // Randomized traffic, random upper address bits and byte offsets
      for (int n = 0; n < 200; n++) begin
         int d;
         int idx;
         bit wr;
         logic [31:0] a;
         d   = int'($urandom_range(0, 2));
         idx = int'($urandom_range(0, 15));
         wr  = 1'($urandom_range(0, 1));
         a   = ($urandom() & ~32'hFFC) | 32'(idx << 2);
         xfer(d, wr, !wr, a, $urandom());
      end

      // Reset in the middle of a WS=3 write
      address[2] = 32'h14; writedata[2] = 32'hDEADBEEF; req_wr[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_waitreq", 32'(waitreq[2]), 32'd1);
      for (int d = 0; d < 3; d++) begin
         chk("rst_readdata", readdata[d], 32'd0);
         chk("rst_perr", 32'(perr[d]), 32'd0);
         rd_m[d] = '0; perr_m[d] = 1'b0;
      end
      req_wr[2] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xfer(2, 1'b0, 1'b1, 32'h14, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
